// File: rtl/topk_sorter_if.sv
// Candidate/result handshake bundle for topk_sorter.
// master drives candidates and result_ready_in; slave is the sorter.
interface topk_sorter_if #(
  parameter int ID_WIDTH = 16
);
  logic                start_in;
  logic                data_valid_in;
  logic [31:0]         distance_sq_in;
  logic [ID_WIDTH-1:0] vertex_id_in;
  logic                last_in;
  logic                ready_out;
  logic                result_valid_out;
  logic                result_ready_in;
  logic [31:0]         result_dist_out;
  logic [ID_WIDTH-1:0] result_id_out;
  logic                result_last_out;
  logic                busy_out;

  modport master (
    output start_in, data_valid_in, distance_sq_in, vertex_id_in, last_in,
    output result_ready_in,
    input  ready_out, result_valid_out, result_dist_out, result_id_out,
    input  result_last_out, busy_out
  );

  modport slave (
    input  start_in, data_valid_in, distance_sq_in, vertex_id_in, last_in,
    input  result_ready_in,
    output ready_out, result_valid_out, result_dist_out, result_id_out,
    output result_last_out, busy_out
  );
endinterface

// File: rtl/topk_sorter.sv
// Streaming K-nearest list: single-cycle sorted insert, then ascending drain.
// Define TOPK_DEDUP_EN to discard candidates whose id already sits in the list.
module topk_sorter #(
  parameter int K        = 4,
  parameter int ID_WIDTH = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  topk_sorter_if.slave bus
);
  localparam int PW = $clog2(K);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [K-1:0]        valid_q, valid_d;
  logic [31:0]         dist_q [K];
  logic [31:0]         dist_d [K];
  logic [ID_WIDTH-1:0] id_q   [K];
  logic [ID_WIDTH-1:0] id_d   [K];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

  logic [K-1:0] le;
  logic [K-1:0] valid_above;
  logic         dup;
  logic         accept;
  logic         insert;
  logic         beat_valid;
  logic         beat_last;

  // le is a thermometer code: valid slots are contiguous and sorted
  always_comb begin
    for (int unsigned i = 0; i < K; i++) begin
      le[i] = valid_q[i] && (dist_q[i] <= bus.distance_sq_in);
    end
  end

`ifdef TOPK_DEDUP_EN
  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < K; i++) begin
      if (valid_q[i] && (id_q[i] == bus.vertex_id_in)) dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign accept      = (state_q == COLLECT) && bus.data_valid_in && !bus.start_in;
  assign insert      = accept && !dup;
  assign valid_above = {1'b0, valid_q[K-1:1]};
  assign beat_valid  = (state_q == DRAIN) && valid_q[rd_ptr_q];
  assign beat_last   = beat_valid && !valid_above[rd_ptr_q];

  assign bus.ready_out        = (state_q == COLLECT);
  assign bus.busy_out         = (state_q != IDLE);
  assign bus.result_valid_out = beat_valid;
  assign bus.result_last_out  = beat_last;
  assign bus.result_dist_out  = beat_valid ? dist_q[rd_ptr_q] : '0;
  assign bus.result_id_out    = beat_valid ? id_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    dist_d   = dist_q;
    id_d     = id_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          valid_d = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.start_in) begin
          valid_d = '0;
        end else begin
          if (insert) begin
            // Slot at the insertion index takes the candidate, slots above take their lower neighbour
            if (!le[0]) begin
              valid_d[0] = 1'b1;
              dist_d[0]  = bus.distance_sq_in;
              id_d[0]    = bus.vertex_id_in;
            end
            for (int unsigned i = 1; i < K; i++) begin
              if (!le[i]) begin
                if (le[i-1]) begin
                  valid_d[i] = 1'b1;
                  dist_d[i]  = bus.distance_sq_in;
                  id_d[i]    = bus.vertex_id_in;
                end else begin
                  valid_d[i] = valid_q[i-1];
                  dist_d[i]  = dist_q[i-1];
                  id_d[i]    = id_q[i-1];
                end
              end
            end
          end
          if (accept && bus.last_in) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
          end
        end
      end
      DRAIN: begin
        if (!beat_valid) begin
          state_d = IDLE;
        end else if (bus.result_ready_in) begin
          if (beat_last) state_d = IDLE;
          else           rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    dist_q <= dist_d;
    id_q   <= id_d;
  end
endmodule

// File: tb/tb_topk_sorter.sv
// Self-checking bench for topk_sorter (K=4): directed table, corner sequences, random queries.
module tb_topk_sorter;
  localparam int K    = 4;
  localparam int ID_W = 16;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  topk_sorter_if #(.ID_WIDTH(ID_W)) ifc ();

  topk_sorter #(.K(K), .ID_WIDTH(ID_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (ifc.slave)
  );

  typedef struct {
    logic [31:0]     d;
    logic [ID_W-1:0] id;
  } ent_t;

  typedef struct {
    int                     n;
    logic [5:0][31:0]       d;
    logic [5:0][ID_W-1:0]   id;
    int                     ne;
    logic [3:0][31:0]       ed;
    logic [3:0][ID_W-1:0]   eid;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t exp_q[$];
  ent_t all_q[$];
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic pulse_start();
    ifc.start_in = 1'b1;
    tick();
    ifc.start_in = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [ID_W-1:0] id, input logic last);
    ifc.data_valid_in  = 1'b1;
    ifc.distance_sq_in = d;
    ifc.vertex_id_in   = id;
    ifc.last_in        = last;
    tick();
    ifc.data_valid_in  = 1'b0;
    ifc.last_in        = 1'b0;
  endtask

  // Expected result list straight from the query's candidate history
  task automatic build_expected();
    ent_t pool[$];
    int   m;
    bit   seen;
    exp_q.delete();
`ifdef TOPK_DEDUP_EN
    foreach (all_q[j]) begin
      seen = 1'b0;
      foreach (exp_q[q]) if (exp_q[q].id == all_q[j].id) seen = 1'b1;
      if (!seen) begin
        m = 0;
        foreach (exp_q[q]) if (exp_q[q].d <= all_q[j].d) m++;
        if (m < K) begin
          exp_q.insert(m, all_q[j]);
          if (exp_q.size() > K) void'(exp_q.pop_back());
        end
      end
    end
`else
    seen = 1'b0;
    pool = all_q;
    while (exp_q.size() < K && pool.size() > 0) begin
      m = 0;
      for (int j = 1; j < pool.size(); j++) if (pool[j].d < pool[m].d) m = j;
      exp_q.push_back(pool[m]);
      pool.delete(m);
    end
`endif
  endtask

  task automatic drain(input string nm, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < exp_q.size() && cyc < 200) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.result_ready_in = rdy;
      if (ifc.result_valid_out) begin
        check({nm, "_dist"}, 64'(ifc.result_dist_out), 64'(exp_q[idx].d));
        check({nm, "_id"},   64'(ifc.result_id_out),   64'(exp_q[idx].id));
        check({nm, "_last"}, 64'(ifc.result_last_out), 64'(idx == exp_q.size() - 1));
        if (rdy) idx++;
      end
      tick();
      cyc++;
    end
    if (idx < exp_q.size()) check({nm, "_beats_timeout"}, 64'(idx), 64'(exp_q.size()));
    ifc.result_ready_in = 1'b0;
    check({nm, "_busy_after"},  64'(ifc.busy_out),         64'd0);
    check({nm, "_valid_after"}, 64'(ifc.result_valid_out), 64'd0);
  endtask

  task automatic addc(input int v, input logic [31:0] d, input logic [ID_W-1:0] id);
    vecs[v].d[vecs[v].n]  = d;
    vecs[v].id[vecs[v].n] = id;
    vecs[v].n++;
  endtask

  task automatic adde(input int v, input logic [31:0] d, input logic [ID_W-1:0] id);
    vecs[v].ed[vecs[v].ne]  = d;
    vecs[v].eid[vecs[v].ne] = id;
    vecs[v].ne++;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ready"}, 64'(ifc.ready_out),        64'd0);
    check({nm, "_rvalid"}, 64'(ifc.result_valid_out), 64'd0);
    check({nm, "_rlast"}, 64'(ifc.result_last_out),  64'd0);
    check({nm, "_busy"},  64'(ifc.busy_out),         64'd0);
    check({nm, "_rdist"}, 64'(ifc.result_dist_out),  64'd0);
    check({nm, "_rid"},   64'(ifc.result_id_out),    64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          n;

    foreach (vecs[v]) begin
      vecs[v].n = 0;
      vecs[v].ne = 0;
      vecs[v].d = '0;
      vecs[v].id = '0;
      vecs[v].ed = '0;
      vecs[v].eid = '0;
    end
    addc(0, 50, 1); addc(0, 10, 2); addc(0, 30, 3); addc(0, 20, 4);
    adde(0, 10, 2); adde(0, 20, 4); adde(0, 30, 3); adde(0, 50, 1);
    addc(1, 40, 1); addc(1, 30, 2); addc(1, 20, 3); addc(1, 10, 4); addc(1, 5, 5); addc(1, 45, 6);
    adde(1, 5, 5); adde(1, 10, 4); adde(1, 20, 3); adde(1, 30, 2);
    addc(2, 32'hFFFF_FFFF, 7);
    adde(2, 32'hFFFF_FFFF, 7);
    addc(3, 12, 4); addc(3, 8, 4); addc(3, 9, 6);
`ifdef TOPK_DEDUP_EN
    adde(3, 9, 6); adde(3, 12, 4);
`else
    adde(3, 8, 4); adde(3, 9, 6); adde(3, 12, 4);
`endif
    addc(4, 32'hFFFF_FFFF, 1); addc(4, 0, 2); addc(4, 32'hFFFF_FFFF, 3); addc(4, 0, 4);
    addc(4, 32'hFFFF_FFFF, 5);
    adde(4, 0, 2); adde(4, 0, 4); adde(4, 32'hFFFF_FFFF, 1); adde(4, 32'hFFFF_FFFF, 3);

    ifc.start_in        = 1'b0;
    ifc.data_valid_in   = 1'b0;
    ifc.distance_sq_in  = '0;
    ifc.vertex_id_in    = '0;
    ifc.last_in         = 1'b0;
    ifc.result_ready_in = 1'b0;
    rst_in = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_in = 1'b0;
    tick();

    // Candidate offered in IDLE is dropped
    ifc.data_valid_in  = 1'b1;
    ifc.distance_sq_in = 1;
    ifc.vertex_id_in   = 77;
    ifc.last_in        = 1'b1;
    check("idle_ready", 64'(ifc.ready_out), 64'd0);
    tick();
    ifc.data_valid_in = 1'b0;
    ifc.last_in       = 1'b0;
    check("idle_busy", 64'(ifc.busy_out), 64'd0);
    pulse_start();
    check("collect_ready", 64'(ifc.ready_out), 64'd1);
    send(5, 1, 1'b1);
    exp_q = '{'{d: 32'd5, id: 16'd1}};
    drain("idle_drop", 1'b0);

    for (int v = 0; v < 5; v++) begin
      pulse_start();
      for (int j = 0; j < vecs[v].n; j++) send(vecs[v].d[j], vecs[v].id[j], 1'(j == vecs[v].n - 1));
      exp_q.delete();
      for (int j = 0; j < vecs[v].ne; j++) exp_q.push_back('{d: vecs[v].ed[j], id: vecs[v].eid[j]});
      drain($sformatf("vec%0d", v), 1'b0);
    end

    // Ties with stalled first beat; start in DRAIN must be ignored
    pulse_start();
    send(7, 9, 1'b0);
    send(7, 3, 1'b0);
    send(7, 5, 1'b1);
    ifc.result_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ifc.start_in = (c == 1);
      tick();
      ifc.start_in = 1'b0;
      check("stall_valid", 64'(ifc.result_valid_out), 64'd1);
      check("stall_dist",  64'(ifc.result_dist_out),  64'd7);
      check("stall_id",    64'(ifc.result_id_out),    64'd9);
      check("stall_last",  64'(ifc.result_last_out),  64'd0);
    end
    exp_q = '{'{d: 32'd7, id: 16'd9}, '{d: 32'd7, id: 16'd3}, '{d: 32'd7, id: 16'd5}};
    drain("ties", 1'b0);

    // start in COLLECT clears list and drops the same-cycle candidate
    pulse_start();
    send(100, 1, 1'b0);
    send(200, 2, 1'b0);
    ifc.start_in       = 1'b1;
    ifc.data_valid_in  = 1'b1;
    ifc.distance_sq_in = 1;
    ifc.vertex_id_in   = 99;
    ifc.last_in        = 1'b1;
    tick();
    ifc.start_in      = 1'b0;
    ifc.data_valid_in = 1'b0;
    ifc.last_in       = 1'b0;
    check("restart_busy",  64'(ifc.busy_out),  64'd1);
    check("restart_ready", 64'(ifc.ready_out), 64'd1);
    send(300, 3, 1'b1);
    exp_q = '{'{d: 32'd300, id: 16'd3}};
    drain("restart", 1'b0);

    // Reset mid-COLLECT, asserted together with start
    pulse_start();
    send(10, 1, 1'b0);
    rst_in       = 1'b1;
    ifc.start_in = 1'b1;
    tick();
    rst_in       = 1'b0;
    ifc.start_in = 1'b0;
    check_reset_outputs("rst_collect");

    // Reset mid-DRAIN
    pulse_start();
    send(1, 1, 1'b0);
    send(2, 2, 1'b1);
    check("pre_rst_drain_valid", 64'(ifc.result_valid_out), 64'd1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_reset_outputs("rst_drain");

    for (int q = 0; q < 40; q++) begin
      pulse_start();
      all_q.delete();
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 20));
        all_q.push_back('{d: d, id: ID_W'($urandom_range(0, 7))});
        send(all_q[j].d, all_q[j].id, 1'(j == n - 1));
      end
      build_expected();
      drain("rand", 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
